mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
- Multiply/divide unit with its own sequencer for the 5-stage MIPS pipeline; sits beside the ALU in the E stage.
- Owns the HI/LO registers.
- Models multi-cycle latency for mult/multu/div/divu with a busy counter.
- Generates the stall request the hazard logic uses to freeze F/D while a D-stage MD instruction cannot proceed.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage MD instruction valid this cycle
- md_op  in  4  operation code (encodings in package)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- d_is_md  in  1  D-stage instruction is any MD op (mult/div/mt*/mf*)
- busy  out  1  long operation in progress
- md_stall  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  mfhi→hi, mflo→lo, else 0 (combinational)

Behaviour:
- Clock and reset: one clock is clk; reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, counter=0, state IDLE. Reset mid-operation aborts; the pending result is discarded.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, counter counts down.
- Accepting a start:
  - A start is accepted only in IDLE. start while BUSY is ignored with no state change; the pipeline guarantees this via md_stall.
- mult/multu/div/divu accepted at edge k:
  - Operands are latched and the 64-bit result is computed into pending registers.
  - counter loads N (MULT_CYCLES or DIV_CYCLES); state goes to BUSY.
  - busy is high for cycles k+1 .. k+N.
  - At edge k+N: hi/lo take the pending result, state returns to IDLE, busy=0.
  - New hi/lo are visible from cycle k+N+1.
- Arithmetic:
  - mult: signed 32x32→64, {hi,lo}=product.
  - multu: unsigned 32x32→64, {hi,lo}=product.
  - div/divu: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt_val=0, div or divu): busy sequence runs normally; hi/lo stay unchanged at completion.
- mthi/mtlo accepted in IDLE: hi (or lo) ← rs_val at that edge; busy stays 0.
- mfhi/mflo/none: no state change. md_op encodings outside the table are treated as none.
- md_stall = d_is_md & (busy | (start & md_op ∈ {mult, multu, div, divu})).
  - Purely combinational.
  - Asserted from the cycle the long op is in E through its last busy cycle.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package mdu_pkg:
  - MD_OP_W=4.
  - Op constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8.
  - State encodings for IDLE/BUSY.
  - Helper function is_long_op.
- Sub-module mdu_arith: combinational; takes op and operands, returns 64-bit {hi,lo} plus a div_by_zero flag. It keeps the signed/unsigned and edge-case rules isolated from the sequencer.

Test Plan:
- mult: rs=0xFFFFFFFE (-2), rt=3 at edge k → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div: rs=-7 (0xFFFFFFF9), rt=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 by -1 → lo=0x80000000, hi=0.
- Stall window: mult in E with d_is_md=1 → md_stall=1 in the start cycle and all 5 busy cycles, 0 the cycle after. The same with d_is_md=0 → md_stall=0 throughout.
- mthi rs=0x12345678, next cycle mflo/mfhi → hi=0x12345678, rd_data=0x12345678 for mfhi; a start of mtlo during BUSY is ignored and lo is unchanged.
- divu by zero with hi=0xAAAA0000, lo=0x5555 preloaded → busy 10 cycles, then hi/lo unchanged.
- reset asserted at busy cycle 3 of div → next cycle busy=0, hi=lo=0, md_stall=0. A following mult completes normally with full latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, sequencer
// states and the long-operation classifier.
package mdu_pkg;

   localparam int MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces {hi,lo} for the four long
// ops and flags division by zero. Signed division is done on magnitudes and
// the signs are restored afterwards, which also makes 0x80000000 / -1 come
// out as 0x80000000 with remainder 0 without any overflow special case.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [MD_OP_W-1:0] op,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   output logic [63:0]        result,
   output logic               div_by_zero
);

   logic        is_signed;
   logic        is_div;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] q;
   logic [31:0] r;

   // Select signed/unsigned operand forms and assemble the result.
   always_comb begin
      is_signed   = (op == MD_MULT) || (op == MD_DIV);
      is_div      = (op == MD_DIV) || (op == MD_DIVU);
      div_by_zero = is_div && (b == 32'd0);

      mul_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      mul_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};

      dvd = (is_signed && a[31]) ? (32'd0 - a) : a;
      dvs = (is_signed && b[31]) ? (32'd0 - b) : b;
      // Guarded divisor keeps the divider defined; the result is discarded anyway.
      if (dvs == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = dvd / dvs;
         ur = dvd % dvs;
      end
      q = (is_signed && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
      r = (is_signed && a[31]) ? (32'd0 - ur) : ur;

      if (is_div) begin
         result = {r, q};
      end else begin
         result = mul_a * mul_b;
      end
   end

endmodule

// File: rtl/mdu_scheduler.sv
// Multiply/divide unit sequencer for the E stage. Owns HI/LO, models the
// multi-cycle latency of mult/div with a down counter, and raises the stall
// request that freezes F/D while a D-stage MD op cannot proceed.
module mdu_scheduler
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        rs_val,
   input  logic [31:0]        rt_val,
   input  logic               d_is_md,
   output logic               busy,
   output logic               md_stall,
   output logic [31:0]        hi,
   output logic [31:0]        lo,
   output logic [31:0]        rd_data
);

   md_state_t   state_reg;
   md_state_t   state_next;
   logic [3:0]  count_reg;
   logic [3:0]  count_next;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic [31:0] pend_hi_reg;
   logic [31:0] pend_lo_reg;
   logic        pend_dbz_reg;

   logic [63:0] arith_result;
   logic        arith_dbz;
   logic        accept;
   logic        done;

   mdu_arith u_arith (
      .op          (md_op),
      .a           (rs_val),
      .b           (rt_val),
      .result      (arith_result),
      .div_by_zero (arith_dbz)
   );

   assign accept = (state_reg == ST_IDLE) && start;
   assign done   = (state_reg == ST_BUSY) && (count_reg == 4'd1);

   // Next state and counter: load latency on a long-op accept, count down while busy.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept && is_long_op(md_op)) begin
               state_next = ST_BUSY;
               if ((md_op == MD_DIV) || (md_op == MD_DIVU)) begin
                  count_next = 4'(DIV_CYCLES);
               end else begin
                  count_next = 4'(MULT_CYCLES);
               end
            end
         end
         ST_BUSY: begin
            count_next = count_reg - 4'd1;
            if (done) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            count_next = 4'd0;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= 4'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // HI/LO and pending result: capture on accept, commit on the last busy edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg       <= 32'd0;
         lo_reg       <= 32'd0;
         pend_hi_reg  <= 32'd0;
         pend_lo_reg  <= 32'd0;
         pend_dbz_reg <= 1'b0;
      end else if (accept) begin
         if (is_long_op(md_op)) begin
            pend_hi_reg  <= arith_result[63:32];
            pend_lo_reg  <= arith_result[31:0];
            pend_dbz_reg <= arith_dbz;
         end else if (md_op == MD_MTHI) begin
            hi_reg <= rs_val;
         end else if (md_op == MD_MTLO) begin
            lo_reg <= rs_val;
         end
      end else if (done && !pend_dbz_reg) begin
         hi_reg <= pend_hi_reg;
         lo_reg <= pend_lo_reg;
      end
   end

   assign busy     = (state_reg == ST_BUSY);
   assign md_stall = d_is_md && (busy || (start && is_long_op(md_op)));
   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign rd_data  = (md_op == MD_MFHI) ? hi_reg :
                     (md_op == MD_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed scenarios with known constants plus a
// randomized run checked against a cycle-level reference of HI/LO and the
// remaining busy count.
module tb_mdu_scheduler;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   int tests;
   int fails;

   // Reference state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pdz;
   int          m_left;

   mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
      .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd);
      start = s; md_op = op; rs_val = a; rt_val = b; d_is_md = dmd;
   endtask

   function automatic logic exp_stall();
      return d_is_md && ((m_left > 0) || (start && (md_op >= 4'd1) && (md_op <= 4'd4)));
   endfunction

   function automatic logic [31:0] exp_rd();
      if (md_op == 4'd7) return m_hi;
      if (md_op == 4'd8) return m_lo;
      return 32'd0;
   endfunction

   // One clock edge; the reference applies the same edge using the inputs present.
   task automatic tick();
      longint sa, sb, sq, sr;
      logic [63:0] p;
      @(posedge clk);
      if (reset) begin
         m_hi = 0; m_lo = 0; m_left = 0; m_pdz = 0; m_phi = 0; m_plo = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && !m_pdz) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else if (start) begin
         sa = longint'(int'(rs_val));
         sb = longint'(int'(rt_val));
         case (md_op)
            4'd1: begin
               sq = sa * sb; p = sq;
               m_phi = p[63:32]; m_plo = p[31:0]; m_pdz = 0; m_left = 5;
            end
            4'd2: begin
               p = {32'd0, rs_val} * {32'd0, rt_val};
               m_phi = p[63:32]; m_plo = p[31:0]; m_pdz = 0; m_left = 5;
            end
            4'd3: begin
               m_pdz = (rt_val == 0); m_left = 10;
               if (!m_pdz) begin
                  sq = sa / sb; sr = sa % sb;
                  m_plo = sq[31:0]; m_phi = sr[31:0];
               end
            end
            4'd4: begin
               m_pdz = (rt_val == 0); m_left = 10;
               if (!m_pdz) begin
                  m_plo = rs_val / rt_val; m_phi = rs_val % rt_val;
               end
            end
            4'd5: m_hi = rs_val;
            4'd6: m_lo = rs_val;
            default: ;
         endcase
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1; set_in(0, MD_NONE, 0, 0, 0);
      tick(); tick();
      reset = 0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
      tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo); end
      tests++; if (md_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b want=0", md_stall); end
   endtask

   task automatic test_mult();
      int nb;
      set_in(1, MD_MULT, 32'hFFFFFFFE, 32'd3, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      nb = 0;
      for (int i = 0; i < 20 && busy === 1'b1; i++) begin nb++; tick(); end
      tests++; if (nb != 5) begin fails++; $display("FAIL mult_latency got=%0d want=5", nb); end
      tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_result got=%h_%h want=ffffffff_fffffffa", hi, lo); end
      set_in(1, MD_MULTU, 32'hFFFFFFFE, 32'd3, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      repeat (5) tick();
      tests++; if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL multu_result got=%h_%h want=00000002_fffffffa", hi, lo); end
   endtask

   task automatic test_div();
      int nb;
      set_in(1, MD_DIV, 32'hFFFFFFF9, 32'd2, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      nb = 0;
      for (int i = 0; i < 20 && busy === 1'b1; i++) begin nb++; tick(); end
      tests++; if (nb != 10) begin fails++; $display("FAIL div_latency got=%0d want=10", nb); end
      tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_result got=%h_%h want=ffffffff_fffffffd", hi, lo); end
      set_in(1, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      repeat (10) tick();
      tests++; if (hi !== 32'd0 || lo !== 32'h80000000) begin fails++; $display("FAIL div_overflow got=%h_%h want=00000000_80000000", hi, lo); end
   endtask

   task automatic test_stall();
      set_in(1, MD_MULT, 32'd7, 32'd9, 1); #1;
      tests++; if (md_stall !== 1'b1) begin fails++; $display("FAIL stall_start got=%b want=1", md_stall); end
      tick();
      set_in(0, MD_NONE, 0, 0, 1);
      for (int i = 1; i <= 5; i++) begin
         #1;
         tests++; if (md_stall !== 1'b1) begin fails++; $display("FAIL stall_busy%0d got=%b want=1", i, md_stall); end
         tick();
      end
      #1;
      tests++; if (md_stall !== 1'b0) begin fails++; $display("FAIL stall_after got=%b want=0", md_stall); end
      set_in(1, MD_MULT, 32'd7, 32'd9, 0); #1;
      for (int i = 0; i <= 5; i++) begin
         tests++; if (md_stall !== 1'b0) begin fails++; $display("FAIL nostall%0d got=%b want=0", i, md_stall); end
         tick();
         set_in(0, MD_NONE, 0, 0, 0); #1;
      end
   endtask

   task automatic test_mt_mf();
      logic [31:0] lo_before;
      set_in(1, MD_MTHI, 32'h12345678, 0, 0); tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got=%b want=0", busy); end
      set_in(1, MD_MFHI, 0, 0, 1); #1;
      tests++; if (hi !== 32'h12345678 || rd_data !== 32'h12345678) begin fails++; $display("FAIL mfhi got hi=%h rd=%h want=12345678", hi, rd_data); end
      tests++; if (md_stall !== 1'b0) begin fails++; $display("FAIL mf_stall got=%b want=0", md_stall); end
      tick();
      set_in(1, MD_MFLO, 0, 0, 0); #1;
      tests++; if (rd_data !== m_lo) begin fails++; $display("FAIL mflo got=%h want=%h", rd_data, m_lo); end
      tick();
      set_in(1, MD_MULT, 32'd3, 32'd4, 0); tick();
      lo_before = lo;
      set_in(1, MD_MTLO, 32'hDEADBEEF, 0, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      tests++; if (lo !== lo_before || busy !== 1'b1) begin fails++; $display("FAIL mtlo_ignored got lo=%h busy=%b want lo=%h busy=1", lo, busy, lo_before); end
      repeat (4) tick();
      tests++; if (lo !== 32'd12 || hi !== 32'd0) begin fails++; $display("FAIL mult_after_ignored got=%h_%h want=00000000_0000000c", hi, lo); end
   endtask

   task automatic test_div_zero();
      int nb;
      set_in(1, MD_MTHI, 32'hAAAA0000, 0, 0); tick();
      set_in(1, MD_MTLO, 32'h00005555, 0, 0); tick();
      set_in(1, MD_DIVU, 32'h1234, 32'd0, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      nb = 0;
      for (int i = 0; i < 20 && busy === 1'b1; i++) begin nb++; tick(); end
      tests++; if (nb != 10) begin fails++; $display("FAIL divz_latency got=%0d want=10", nb); end
      tests++; if (hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin fails++; $display("FAIL divz_hilo got=%h_%h want=aaaa0000_00005555", hi, lo); end
   endtask

   task automatic test_reset_mid();
      int nb;
      set_in(1, MD_DIV, 32'd100, 32'd7, 1); tick();
      set_in(0, MD_NONE, 0, 0, 1);
      tick(); tick();
      reset = 1; tick(); reset = 0; #1;
      tests++; if (busy !== 1'b0 || md_stall !== 1'b0) begin fails++; $display("FAIL rstmid_busy got busy=%b stall=%b want 0/0", busy, md_stall); end
      tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL rstmid_hilo got=%h_%h want=0_0", hi, lo); end
      set_in(1, MD_MULT, 32'd6, 32'hFFFFFFFF, 0); tick();
      set_in(0, MD_NONE, 0, 0, 0);
      nb = 0;
      for (int i = 0; i < 20 && busy === 1'b1; i++) begin nb++; tick(); end
      tests++; if (nb != 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL rstmid_mult got n=%0d %h_%h want n=5 ffffffff_fffffffa", nb, hi, lo); end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 79) == 0);
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
         set_in($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), a, b, $urandom_range(0, 1) == 1);
         #1;
         tests++; if (md_stall !== exp_stall() || rd_data !== exp_rd()) begin fails++; $display("FAIL rand_comb%0d got stall=%b rd=%h want stall=%b rd=%h", i, md_stall, rd_data, exp_stall(), exp_rd()); end
         tick();
         tests++; if (busy !== (m_left > 0) || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL rand_state%0d got busy=%b %h_%h want busy=%b %h_%h", i, busy, hi, lo, m_left > 0, m_hi, m_lo); end
      end
      reset = 0;
   endtask

   initial begin
      tests = 0; fails = 0;
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pdz = 0; m_left = 0;
      reset = 1;
      set_in(0, MD_NONE, 0, 0, 0);
      test_reset();
      test_mult();
      test_div();
      test_stall();
      test_mt_mf();
      test_div_zero();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
